// File: rtl/gpio_disp_pkg.sv
// rtl/gpio_disp_pkg.sv - shared constants and types for the GPIO seven-segment display controller
package gpio_disp_pkg;

  localparam int unsigned DIGIT_CYCLES_DEF = 4;
  localparam int unsigned BLINK_FRAMES_DEF = 8;

  localparam int unsigned CTRL_SEL_BIT = 4;
  localparam int unsigned CTRL_ERR_BIT = 0;

  // Active-low glyphs, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] GLYPH_BLANK = 7'b1111111;
  localparam logic [6:0] GLYPH_E     = 7'b0000110;
  localparam logic [6:0] GLYPH_R     = 7'b0101111;

  typedef struct packed {
    logic [31:0] data;
    logic        sel;
    logic        err;
  } shadow_t;

  function automatic logic [6:0] err_glyph(input logic [1:0] digit);
    logic [6:0] g;
    case (digit)
      2'd3:       g = GLYPH_E;
      2'd2, 2'd1: g = GLYPH_R;
      default:    g = GLYPH_BLANK;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/gpio_disp_ctrl_if.sv
// rtl/gpio_disp_ctrl_if.sv - SoC GPIO words in, multiplexed seven-segment drives out
interface gpio_disp_ctrl_if;

  logic [31:0] gp_data;
  logic [31:0] gp_ctrl;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_tick;

  modport master (output gp_data, gp_ctrl, input an, seg, dp, frame_tick);
  modport slave  (input gp_data, gp_ctrl, output an, seg, dp, frame_tick);

endinterface

// File: rtl/hex7seg_dec.sv
// rtl/hex7seg_dec.sv - nibble to active-low seven-segment glyph, lowercase b and d
module hex7seg_dec
  import gpio_disp_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = GLYPH_BLANK;
    case (nibble_i)
      4'h0: seg_o = 7'b1000000;
      4'h1: seg_o = 7'b1111001;
      4'h2: seg_o = 7'b0100100;
      4'h3: seg_o = 7'b0110000;
      4'h4: seg_o = 7'b0011001;
      4'h5: seg_o = 7'b0010010;
      4'h6: seg_o = 7'b0000010;
      4'h7: seg_o = 7'b1111000;
      4'h8: seg_o = 7'b0000000;
      4'h9: seg_o = 7'b0010000;
      4'hA: seg_o = 7'b0001000;
      4'hB: seg_o = 7'b0000011;
      4'hC: seg_o = 7'b1000110;
      4'hD: seg_o = 7'b0100001;
      4'hE: seg_o = 7'b0000110;
      4'hF: seg_o = 7'b0001110;
      default: seg_o = GLYPH_BLANK;
    endcase
  end

endmodule

// File: rtl/gpio_disp_ctrl.sv
// rtl/gpio_disp_ctrl.sv - scans four digits from a frame-captured copy of the GPIO words
// and blinks an "Err" message while the captured error flag is set.
module gpio_disp_ctrl
  import gpio_disp_pkg::*;
#(
  parameter int unsigned DIGIT_CYCLES = DIGIT_CYCLES_DEF,
  parameter int unsigned BLINK_FRAMES = BLINK_FRAMES_DEF
) (
  input  logic            clk,
  input  logic            rst,
  gpio_disp_ctrl_if.slave bus
);

  localparam int unsigned CW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CW-1:0] CYC_LAST   = CW'(DIGIT_CYCLES - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

  logic [CW-1:0] cyc_cnt_q, cyc_cnt_d;
  logic [1:0]    digit_q, digit_d;
  logic [FW-1:0] frame_cnt_q, frame_cnt_d;
  logic          blink_q, blink_d;
  shadow_t       shadow_q, shadow_d;
  logic          tick_q;

  logic          cyc_wrap;
  logic          capture;
  logic          frame_wrap;
  logic [15:0]   half;
  logic [3:0]    nibble;
  logic [6:0]    hex_glyph;
  logic          unused_ctrl;

  assign cyc_wrap   = (cyc_cnt_q == CYC_LAST);
  assign capture    = cyc_wrap && (digit_q == 2'd3);
  assign frame_wrap = (frame_cnt_q == FRAME_LAST);

  // Inputs only ever reach the display through the shadow copy taken at a frame boundary
  always_comb begin
    cyc_cnt_d   = cyc_wrap ? '0 : cyc_cnt_q + 1'b1;
    digit_d     = cyc_wrap ? digit_q + 2'd1 : digit_q;
    frame_cnt_d = frame_cnt_q;
    blink_d     = blink_q;
    shadow_d    = shadow_q;
    if (capture) begin
      frame_cnt_d   = frame_wrap ? '0 : frame_cnt_q + 1'b1;
      blink_d       = blink_q ^ frame_wrap;
      shadow_d.data = bus.gp_data;
      shadow_d.sel  = bus.gp_ctrl[CTRL_SEL_BIT];
      shadow_d.err  = bus.gp_ctrl[CTRL_ERR_BIT];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc_cnt_q   <= '0;
      digit_q     <= '0;
      frame_cnt_q <= '0;
      blink_q     <= 1'b1;
      shadow_q    <= '0;
      tick_q      <= 1'b0;
    end else begin
      cyc_cnt_q   <= cyc_cnt_d;
      digit_q     <= digit_d;
      frame_cnt_q <= frame_cnt_d;
      blink_q     <= blink_d;
      shadow_q    <= shadow_d;
      tick_q      <= capture;
    end
  end

  assign half   = shadow_q.sel ? shadow_q.data[31:16] : shadow_q.data[15:0];
  assign nibble = half[{digit_q, 2'b00} +: 4];

  hex7seg_dec u_dec (
    .nibble_i (nibble),
    .seg_o    (hex_glyph)
  );

  assign bus.an         = ~(4'b0001 << digit_q);
  assign bus.seg        = !shadow_q.err ? hex_glyph
                        : (blink_q ? err_glyph(digit_q) : GLYPH_BLANK);
  assign bus.dp         = ~((digit_q == 2'd0) && shadow_q.sel);
  assign bus.frame_tick = tick_q;

  assign unused_ctrl = ^{bus.gp_ctrl[31:5], bus.gp_ctrl[3:1]};

endmodule

// File: tb/tb_gpio_disp_ctrl.sv
// tb/tb_gpio_disp_ctrl.sv - self-checking bench for gpio_disp_ctrl
module tb_gpio_disp_ctrl;

  localparam int DC0 = 4;
  localparam int BF0 = 2;
  localparam int DC1 = 1;
  localparam int BF1 = 3;
  localparam int DCS [2] = '{DC0, DC1};
  localparam int BFS [2] = '{BF0, BF1};

  localparam logic [6:0] HEX_TAB [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  localparam logic [6:0] G_BLANK = 7'h7F;
  localparam logic [6:0] G_E     = 7'h06;
  localparam logic [6:0] G_R     = 7'h2F;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       tick;
  } outs_t;

  typedef struct {
    logic [31:0] data;
    logic [31:0] ctrl;
    int          cyc;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        tick;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] gp_data = '0;
  logic [31:0] gp_ctrl = '0;
  logic        model_on = 1'b0;
  int          n_checks = 0;
  int          n_fail = 0;

  int unsigned m_n    [2];
  logic [31:0] m_data [2];
  logic        m_sel  [2];
  logic        m_err  [2];

  vec_t vecs[$];

  always #5 clk = ~clk;

  gpio_disp_ctrl_if if0 ();
  gpio_disp_ctrl_if if1 ();

  assign if0.gp_data = gp_data;
  assign if0.gp_ctrl = gp_ctrl;
  assign if1.gp_data = gp_data;
  assign if1.gp_ctrl = gp_ctrl;

  gpio_disp_ctrl #(.DIGIT_CYCLES(DC0), .BLINK_FRAMES(BF0)) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (if0)
  );

  gpio_disp_ctrl #(.DIGIT_CYCLES(DC1), .BLINK_FRAMES(BF1)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (if1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected outputs after n edges since reset, from the frame-level rules
  function automatic outs_t model_out(input int unsigned n, input logic [31:0] d, input logic sel,
                                      input logic err, input int unsigned dc, input int unsigned bf);
    outs_t       o;
    int unsigned dig;
    int unsigned caps;
    logic        blink;
    logic [15:0] half;
    dig   = (n / dc) % 4;
    caps  = n / (4 * dc);
    blink = ((caps / bf) % 2) == 0;
    half  = sel ? d[31:16] : d[15:0];
    o.an   = ~(4'b0001 << dig);
    o.tick = (n != 0) && ((n % (4 * dc)) == 0);
    o.dp   = !((dig == 0) && sel);
    if (!err)        o.seg = HEX_TAB[half[dig*4 +: 4]];
    else if (!blink) o.seg = G_BLANK;
    else if (dig == 3) o.seg = G_E;
    else if (dig == 0) o.seg = G_BLANK;
    else             o.seg = G_R;
    return o;
  endfunction

  task automatic chk_dut(input int idx, input outs_t act);
    outs_t exp;
    exp = model_out(m_n[idx], m_data[idx], m_sel[idx], m_err[idx], DCS[idx], BFS[idx]);
    check($sformatf("model%0d_an", idx), {28'b0, act.an}, {28'b0, exp.an});
    check($sformatf("model%0d_seg", idx), {25'b0, act.seg}, {25'b0, exp.seg});
    check($sformatf("model%0d_dp", idx), {31'b0, act.dp}, {31'b0, exp.dp});
    check($sformatf("model%0d_tick", idx), {31'b0, act.tick}, {31'b0, exp.tick});
  endtask

  function automatic void add(input logic [31:0] data, input logic [31:0] ctrl, input int cyc,
                              input logic [3:0] an, input logic [6:0] seg, input logic dp,
                              input logic tick);
    vec_t v;
    v.data = data; v.ctrl = ctrl; v.cyc = cyc;
    v.an = an; v.seg = seg; v.dp = dp; v.tick = tick;
    vecs.push_back(v);
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        m_n[i] <= 0; m_data[i] <= '0; m_sel[i] <= 1'b0; m_err[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        m_n[i] <= m_n[i] + 1;
        if (((m_n[i] + 1) % (4 * DCS[i])) == 0) begin
          m_data[i] <= gp_data;
          m_sel[i]  <= gp_ctrl[4];
          m_err[i]  <= gp_ctrl[0];
        end
      end
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      chk_dut(0, {if0.an, if0.seg, if0.dp, if0.frame_tick});
      chk_dut(1, {if1.an, if1.seg, if1.dp, if1.frame_tick});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] an_seq [4];
    logic       shown;
    int         first;
    an_seq = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    // Frame 0 shows the cleared shadow; frame 1 the captured d C b A
    add(32'h1234ABCD, 32'h0, 3, 4'b1110, HEX_TAB[0], 1'b1, 1'b0);
    add(32'h1234ABCD, 32'h0, 4, 4'b1101, HEX_TAB[0], 1'b1, 1'b0);
    add(32'h1234ABCD, 32'h0, 4, 4'b1011, HEX_TAB[0], 1'b1, 1'b0);
    add(32'h1234ABCD, 32'h0, 4, 4'b0111, HEX_TAB[0], 1'b1, 1'b0);
    add(32'h1234ABCD, 32'h0, 4, 4'b1110, HEX_TAB[13], 1'b1, 1'b1);
    add(32'h1234ABCD, 32'h0, 4, 4'b1101, HEX_TAB[12], 1'b1, 1'b0);
    add(32'h1234ABCD, 32'h0, 4, 4'b1011, HEX_TAB[11], 1'b1, 1'b0);
    add(32'h1234ABCD, 32'h10, 4, 4'b0111, HEX_TAB[10], 1'b1, 1'b0);
    // Upper half selected; data changes mid-frame without effect
    add(32'h1234ABCD, 32'h10, 4, 4'b1110, HEX_TAB[4], 1'b0, 1'b1);
    add(32'h0000FFFF, 32'h0, 4, 4'b1101, HEX_TAB[3], 1'b1, 1'b0);
    add(32'h0000FFFF, 32'h0, 4, 4'b1011, HEX_TAB[2], 1'b1, 1'b0);
    add(32'h0000FFFF, 32'h0, 4, 4'b0111, HEX_TAB[1], 1'b1, 1'b0);
    add(32'h0000FFFF, 32'h0, 4, 4'b1110, HEX_TAB[15], 1'b1, 1'b1);
    add(32'h0000FFFF, 32'h0, 4, 4'b1101, HEX_TAB[15], 1'b1, 1'b0);
    add(32'h0000FFFF, 32'h1, 4, 4'b1011, HEX_TAB[15], 1'b1, 1'b0);
    add(32'h0000FFFF, 32'h1, 4, 4'b0111, HEX_TAB[15], 1'b1, 1'b0);
    for (int f = 4; f <= 8; f++) begin
      shown = (f != 6) && (f != 7);
      add(32'h0000FFFF, 32'h1, 4, 4'b1110, G_BLANK, 1'b1, 1'b1);
      add(32'h0000FFFF, 32'h1, 4, 4'b1101, shown ? G_R : G_BLANK, 1'b1, 1'b0);
      add(32'h0000FFFF, 32'h1, 4, 4'b1011, shown ? G_R : G_BLANK, 1'b1, 1'b0);
      add(32'h0000FFFF, 32'h1, 4, 4'b0111, shown ? G_E : G_BLANK, 1'b1, 1'b0);
    end

    gp_data = 32'h1234ABCD;
    gp_ctrl = 32'h0;
    #1 rst = 1'b0;
    #1;
    model_on = 1'b1;
    check("reset_an", {28'b0, if0.an}, 32'h0000000E);
    check("reset_seg", {25'b0, if0.seg}, 32'h00000040);
    check("reset_dp", {31'b0, if0.dp}, 32'h1);
    check("reset_tick", {31'b0, if0.frame_tick}, 32'h0);
    repeat (3) @(negedge clk);
    check("reset_hold_an", {28'b0, if0.an}, 32'h0000000E);
    check("reset_hold_seg", {25'b0, if0.seg}, 32'h00000040);
    rst = 1'b1;

    foreach (vecs[v]) begin
      gp_data = vecs[v].data;
      gp_ctrl = vecs[v].ctrl;
      for (int c = 0; c < vecs[v].cyc; c++) begin
        @(negedge clk);
        check($sformatf("tab%0d_an", v), {28'b0, if0.an}, {28'b0, vecs[v].an});
        check($sformatf("tab%0d_seg", v), {25'b0, if0.seg}, {25'b0, vecs[v].seg});
        check($sformatf("tab%0d_dp", v), {31'b0, if0.dp}, {31'b0, vecs[v].dp});
        check($sformatf("tab%0d_tick", v), {31'b0, if0.frame_tick},
              {31'b0, (vecs[v].tick && (c == 0))});
      end
    end

    // Asynchronous reset pulse between edges while digit 2 is driven
    repeat (9) @(negedge clk);
    check("pre_rst_an", {28'b0, if0.an}, 32'h0000000B);
    #2 rst = 1'b0;
    #1;
    check("async_rst_an", {28'b0, if0.an}, 32'h0000000E);
    check("async_rst_seg", {25'b0, if0.seg}, 32'h00000040);
    check("async_rst_dp", {31'b0, if0.dp}, 32'h1);
    check("async_rst_tick", {31'b0, if0.frame_tick}, 32'h0);
    check("async_rst_an1", {28'b0, if1.an}, 32'h0000000E);
    #1 rst = 1'b1;
    first = -1;
    for (int e = 1; e <= 40 && first < 0; e++) begin
      @(negedge clk);
      if (if0.frame_tick) first = e;
      if (e <= 8) begin
        check($sformatf("dc1_an_e%0d", e), {28'b0, if1.an}, {28'b0, an_seq[e % 4]});
        check($sformatf("dc1_tick_e%0d", e), {31'b0, if1.frame_tick}, {31'b0, ((e % 4) == 0)});
      end
    end
    check("first_tick_after_rst", first, 32'd16);

    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      gp_data = $urandom;
      gp_ctrl = $urandom;
      gp_ctrl[0] = ($urandom_range(3) == 0);
      if ($urandom_range(99) == 0) begin
        #2 rst = 1'b0;
        #2 rst = 1'b1;
      end
    end
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
